snake_mem_arbiter: RTL and testbench

//  Sole owner of the snake_memory access port; sits between game_logic, coord2grid_translator and snake_memory.

---
 rtl/snake_mem_arbiter_pkg.sv | 7 +
 rtl/snake_mem_arbiter_frame_tick_gen.sv | 29 ++
 rtl/snake_mem_arbiter.sv | 76 +++++++
 tb/tb_snake_mem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_mem_arbiter_pkg.sv
// snake_mem_arbiter_pkg: shared widths, direction codes and arbiter state encodings
package snake_mem_arbiter_pkg;
    localparam int WORD_MSB      = 7;
    localparam int MSB_NUM_TAILS = 5;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic [1:0] {RENDER, STEP, HANDBACK} arb_state_t;
endpackage

// File: rtl/snake_mem_arbiter_frame_tick_gen.sv
// snake_mem_arbiter_frame_tick_gen: vertical-blank entry detect and frame counter that flags a due game step
module snake_mem_arbiter_frame_tick_gen #(
    parameter int V_ACTIVE        = 480,
    parameter int FRAMES_PER_STEP = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] vga_y,
    input  logic       count_en,
    output logic       step_due
);
    logic       blank;
    logic       blank_q;
    logic       blank_rise;
    logic [7:0] frame_cnt;
    assign blank      = vga_y >= 10'(V_ACTIVE);
    assign blank_rise = blank & ~blank_q;
    // frames are only counted while the translator owns the port
    assign step_due   = blank_rise & count_en & (frame_cnt == 8'(FRAMES_PER_STEP - 1));
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            blank_q <= blank;
            if (blank_rise & count_en) frame_cnt <= step_due ? '0 : frame_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/snake_mem_arbiter.sv
// snake_mem_arbiter: owns the snake_memory port, renderer during video, game logic every N frames in blank.
// Define SNAKE_ARB_TIMEOUT_EN to add the step watchdog (abort on blank exit or STEP_MAX_CYCLES).
module snake_mem_arbiter
    import snake_mem_arbiter_pkg::*;
#(
    parameter int V_ACTIVE        = 480,
    parameter int FRAMES_PER_STEP = 15,
    parameter int STEP_MAX_CYCLES = 30000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [9:0]             vga_y,
    input  logic                   logic_we,
    input  logic [MSB_NUM_TAILS:0] logic_addr,
    input  logic [WORD_MSB:0]      render_addr,
    input  logic                   step_done,
    output logic                   logic_gnt,
    output logic                   render_gnt,
    output logic                   step_start,
    output logic                   step_abort,
    output logic                   mem_we,
    output logic [WORD_MSB:0]      mem_addr
);
    if (FRAMES_PER_STEP < 1 || FRAMES_PER_STEP > 255 || STEP_MAX_CYCLES < 1 || STEP_MAX_CYCLES > 32768) begin : g_bad_cfg
        $error("snake_mem_arbiter: parameter out of range");
    end
    arb_state_t state, state_nxt;
    logic       step_due;
    logic       done_ok;
    logic       timeout;
    logic       abort_now;
    snake_mem_arbiter_frame_tick_gen #(
        .V_ACTIVE(V_ACTIVE),
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_tick (
        .clk(clk),
        .reset(reset),
        .vga_y(vga_y),
        .count_en(state == RENDER),
        .step_due(step_due)
    );
`ifdef SNAKE_ARB_TIMEOUT_EN
    logic [14:0] step_cyc;
    always_ff @(posedge clk) step_cyc <= (reset || state != STEP) ? '0 : step_cyc + 15'd1;
    assign timeout = (vga_y < 10'(V_ACTIVE)) | (step_cyc == 15'(STEP_MAX_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif
    // the step_start cycle is game_logic's first cycle; a stale step_done there is ignored
    assign done_ok = step_done & ~step_start;
    always_comb begin
        state_nxt = state;
        abort_now = 1'b0;
        if (state == RENDER && step_due) state_nxt = STEP;
        else if (state == STEP && done_ok) state_nxt = HANDBACK;
        else if (state == STEP && timeout) begin
            state_nxt = HANDBACK;
            abort_now = 1'b1;
        end else if (state == HANDBACK) state_nxt = RENDER;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RENDER;
            step_start <= 1'b0;
            step_abort <= 1'b0;
        end else begin
            state      <= state_nxt;
            step_start <= state == RENDER && step_due;
            step_abort <= abort_now;
        end
    end
    assign render_gnt = state == RENDER;
    assign logic_gnt  = state == STEP;
    assign mem_we     = logic_gnt & logic_we;
    assign mem_addr   = logic_gnt ? {{(WORD_MSB - MSB_NUM_TAILS){1'b0}}, logic_addr} : render_addr;
endmodule

// File: tb/tb_snake_mem_arbiter.sv
// tb_snake_mem_arbiter: vector table, corner-case sequences and randomized run against a behavioural model
module tb_snake_mem_arbiter;
    import snake_mem_arbiter_pkg::*;
    localparam int FPS  = 2;
    localparam int MAXC = 100;
`ifdef SNAKE_ARB_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif
    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [9:0]             vga_y = '0;
    logic                   logic_we = 1'b0;
    logic [MSB_NUM_TAILS:0] logic_addr = '0;
    logic [WORD_MSB:0]      render_addr = '0;
    logic                   step_done = 1'b0;
    logic                   logic_gnt, render_gnt, step_start, step_abort, mem_we;
    logic [WORD_MSB:0]      mem_addr;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [9:0] y;
        logic       we;
        logic [5:0] la;
        logic [7:0] ra;
        logic       dn;
        logic       rg;
        logic       lg;
        logic       mwe;
        logic [7:0] ma;
        logic       ss;
    } vec_t;
    vec_t tbl[10];

    int  m_mode, m_frames, m_k;
    bit  m_prev, m_ss, m_ab;

    always #5 clk = ~clk;

    snake_mem_arbiter #(.V_ACTIVE(480), .FRAMES_PER_STEP(FPS), .STEP_MAX_CYCLES(MAXC)) dut (
        .clk(clk), .reset(reset), .vga_y(vga_y), .logic_we(logic_we), .logic_addr(logic_addr),
        .render_addr(render_addr), .step_done(step_done), .logic_gnt(logic_gnt), .render_gnt(render_gnt),
        .step_start(step_start), .step_abort(step_abort), .mem_we(mem_we), .mem_addr(mem_addr)
    );

    function automatic vec_t v(int y, int we, int la, int ra, int dn, int rg, int lg, int mwe, int ma, int ss);
        v.y = 10'(y); v.we = 1'(we); v.la = 6'(la); v.ra = 8'(ra); v.dn = 1'(dn);
        v.rg = 1'(rg); v.lg = 1'(lg); v.mwe = 1'(mwe); v.ma = 8'(ma); v.ss = 1'(ss);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1; vga_y = '0; logic_we = 1'b0; step_done = 1'b0;
        repeat (3) tick;
        reset = 1'b0;
    endtask

    // two blank entries with FPS=2: the DUT is in its first STEP cycle on return
    task automatic enter_step;
        do_reset;
        vga_y = 10'd480; tick;
        vga_y = 10'd0;   tick;
        vga_y = 10'd480; tick;
    endtask

    // reference: one clock edge of the arbiter's externally visible behaviour
    task automatic model_edge;
        bit b;
        b = vga_y >= 10'd480;
        if (reset) begin
            m_mode = 0; m_frames = 0; m_prev = 1'b0; m_ss = 1'b0; m_ab = 1'b0; m_k = 0;
        end else begin
            m_ss = 1'b0; m_ab = 1'b0;
            if (m_mode == 0) begin
                if (b && !m_prev) begin
                    if (m_frames == FPS - 1) begin
                        m_frames = 0; m_mode = 1; m_k = 0; m_ss = 1'b1;
                    end else m_frames++;
                end
            end else if (m_mode == 1) begin
                m_k++;
                if (m_k > 1 && step_done) m_mode = 2;
                else if (WD && (!b || m_k == MAXC)) begin
                    m_mode = 2; m_ab = 1'b1;
                end
            end else m_mode = 0;
            m_prev = b;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int pulses, pos_ok, ticks, errs, ph;
        tbl[0] = v(479, 1, 3, 9, 0,  1, 0, 0, 9, 0);
        tbl[1] = v(480, 1, 3, 9, 1,  1, 0, 0, 9, 0);
        tbl[2] = v(481, 0, 3, 9, 0,  1, 0, 0, 9, 0);
        tbl[3] = v(100, 0, 3, 9, 0,  1, 0, 0, 9, 0);
        tbl[4] = v(479, 0, 3, 9, 0,  1, 0, 0, 9, 0);
        tbl[5] = v(480, 1, 3, 9, 0,  0, 1, 1, 3, 1);
        tbl[6] = v(481, 1, 3, 9, 1,  0, 1, 1, 3, 0);
        tbl[7] = v(482, 0, 5, 9, 1,  0, 0, 0, 9, 0);
        tbl[8] = v(483, 0, 5, 9, 0,  1, 0, 0, 9, 0);
        tbl[9] = v(490, 0, 0, 4, 1,  1, 0, 0, 4, 0);

        reset = 1'b1; render_addr = 8'd7;
        repeat (3) tick;
        chk("rst_render_gnt", render_gnt, 1);
        chk("rst_logic_gnt", logic_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 7);
        chk("rst_step_start", step_start, 0);
        chk("rst_step_abort", step_abort, 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            vga_y = tbl[i].y; logic_we = tbl[i].we; logic_addr = tbl[i].la;
            render_addr = tbl[i].ra; step_done = tbl[i].dn;
            tick;
            chk($sformatf("vec%0d_render_gnt", i), render_gnt, tbl[i].rg);
            chk($sformatf("vec%0d_logic_gnt", i), logic_gnt, tbl[i].lg);
            chk($sformatf("vec%0d_mem_we", i), mem_we, tbl[i].mwe);
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, tbl[i].ma);
            chk($sformatf("vec%0d_step_start", i), step_start, tbl[i].ss);
        end

        do_reset;
        pulses = 0; pos_ok = 0;
        for (int s = 0; s < 2; s++)
            for (int y = 0; y < 525; y++) begin
                vga_y = 10'(y);
                tick;
                if (step_start) begin
                    pulses++;
                    if (s == 1 && y == 480 && logic_gnt) pos_ok = 1;
                end
            end
        chk("sweep_pulses", pulses, 1);
        chk("sweep_pulse_position", pos_ok, 1);

        enter_step;
        chk("enter_logic_gnt", logic_gnt, 1);
        step_done = 1'b0;
`ifdef SNAKE_ARB_TIMEOUT_EN
        ticks = 0;
        while (!step_abort && ticks < 200) begin
            tick;
            ticks++;
        end
        chk("wd_abort_cycle", ticks, MAXC);
        chk("wd_handback_render_gnt", render_gnt, 0);
        tick;
        chk("wd_render_gnt", render_gnt, 1);
        chk("wd_abort_pulse", step_abort, 0);
        enter_step;
        repeat (MAXC - 1) tick;
        step_done = 1'b1;
        tick;
        step_done = 1'b0;
        chk("done_wins_abort", step_abort, 0);
        chk("done_wins_logic_gnt", logic_gnt, 0);
        tick;
        chk("done_wins_render_gnt", render_gnt, 1);
`else
        errs = 0;
        repeat (1000) begin
            tick;
            if (!logic_gnt || render_gnt || step_abort) errs++;
        end
        chk("hold_step_errors", errs, 0);
`endif

        enter_step;
        repeat (4) tick;
        reset = 1'b1;
        tick;
        chk("midrst_render_gnt", render_gnt, 1);
        chk("midrst_logic_gnt", logic_gnt, 0);
        chk("midrst_step_abort", step_abort, 0);
        chk("midrst_frame_cnt", dut.u_tick.frame_cnt, 0);

        ph = 0;
        for (int c = 0; c < 4000; c++) begin
            reset = (c < 3) || ($urandom_range(0, 299) == 0);
            ph = (ph + 1) % 30;
            vga_y = ($urandom_range(0, 19) == 0) ? 10'($urandom_range(0, 524)) : 10'(460 + ph);
            logic_we = 1'($urandom);
            logic_addr = 6'($urandom);
            render_addr = 8'($urandom);
            step_done = $urandom_range(0, 5) == 0;
            model_edge;
            tick;
            chk("rnd_render_gnt", render_gnt, m_mode == 0);
            chk("rnd_logic_gnt", logic_gnt, m_mode == 1);
            chk("rnd_mem_we", mem_we, m_mode == 1 && logic_we);
            chk("rnd_mem_addr", mem_addr, m_mode == 1 ? {2'b00, logic_addr} : render_addr);
            chk("rnd_step_start", step_start, m_ss);
            chk("rnd_step_abort", step_abort, m_ab);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
